// File: rtl/battle_sequencer.sv
// -----------------------------------------------------------------------------
// battle_sequencer
//
// Turn sequencer for a two-party battle. It alternates a player turn and an
// enemy turn, applies the damage each attack block reports, holds a result
// phase between rounds and ends in WIN or LOSE when a side's hit points
// reach zero.
//
// Ports
//   clk                 system clock, all state changes on its rising edge
//   rst_n               asynchronous active-low reset
//   start_in            level: leaves IDLE to start a battle, or leaves WIN/LOSE
//   player_finished_in  finished flag from the player attack block
//   player_damage_in    damage dealt to the enemy, sampled with the flag
//   enemy_finished_in   finished flag from the enemy attack block
//   enemy_damage_in     damage dealt to the player, sampled with the flag
//   state_out           current phase code (registered), also the debug view
//   player_hp_out       player hit points
//   enemy_hp_out        enemy hit points
//   turn_count_out      completed player+enemy rounds, saturating at 8'hFF
//   timeout_out         one-cycle pulse when a turn is aborted by timeout
//
// Handshake: a finished flag is a qualifier, not a valid/ready pair. It is
// accepted only in the matching turn and only after the two-cycle entry
// mask; the damage input is read in exactly that cycle and ignored otherwise.
// -----------------------------------------------------------------------------
module battle_sequencer #(
  parameter logic [7:0]  PLAYER_HP_INIT     = 8'd100,
  parameter logic [7:0]  ENEMY_HP_INIT      = 8'd200,
  parameter logic [31:0] TIMEOUT_CYCLES     = 32'd650_000_000,
  parameter logic [31:0] RESULT_HOLD_CYCLES = 32'd130_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_in,
  input  logic       player_finished_in,
  input  logic [7:0] player_damage_in,
  input  logic       enemy_finished_in,
  input  logic [7:0] enemy_damage_in,
  output logic [3:0] state_out,
  output logic [7:0] player_hp_out,
  output logic [7:0] enemy_hp_out,
  output logic [7:0] turn_count_out,
  output logic       timeout_out
);

  typedef enum logic [3:0] {
    IDLE        = 4'b0000,
    PLAYER_TURN = 4'b0001,
    ENEMY_TURN  = 4'b0010,
    RESULT      = 4'b0011,
    WIN         = 4'b0100,
    LOSE        = 4'b0101
  } state_t;

  state_t      state;
  logic [31:0] timer;   // cycles spent in the current phase
  logic [1:0]  guard;   // counts up to 2 after turn entry; finished masked below 2

  logic       guard_open;
  logic       turn_expired;
  logic       hold_done;
  logic       player_accept;
  logic       enemy_accept;
  logic [7:0] enemy_hp_next;
  logic [7:0] player_hp_next;

  function automatic logic [7:0] sat_sub(input logic [7:0] hp, input logic [7:0] dmg);
    return (dmg >= hp) ? 8'd0 : hp - dmg;
  endfunction

  assign guard_open    = (guard == 2'd2);
  assign turn_expired  = (timer == TIMEOUT_CYCLES - 32'd1);
  assign hold_done     = (timer == RESULT_HOLD_CYCLES - 32'd1);
  assign player_accept = guard_open && player_finished_in;
  assign enemy_accept  = guard_open && enemy_finished_in;

  // A timed-out turn applies zero damage, so the same subtraction path is used.
  assign enemy_hp_next  = sat_sub(enemy_hp_out,  player_accept ? player_damage_in : 8'd0);
  assign player_hp_next = sat_sub(player_hp_out, enemy_accept  ? enemy_damage_in  : 8'd0);

  assign state_out = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      player_hp_out  <= PLAYER_HP_INIT;
      enemy_hp_out   <= ENEMY_HP_INIT;
      turn_count_out <= 8'd0;
      timeout_out    <= 1'b0;
      timer          <= 32'd0;
      guard          <= 2'd0;
    end else begin
      timeout_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            state <= PLAYER_TURN;
            timer <= 32'd0;
            guard <= 2'd0;
          end
        end

        PLAYER_TURN: begin
          // Finished takes priority over an expiring timer in the same cycle.
          if (player_accept || turn_expired) begin
            enemy_hp_out <= enemy_hp_next;
            timeout_out  <= ~player_accept;
            state        <= (enemy_hp_next == 8'd0) ? WIN : ENEMY_TURN;
            timer        <= 32'd0;
            guard        <= 2'd0;
          end else begin
            timer <= timer + 32'd1;
            if (!guard_open) guard <= guard + 2'd1;
          end
        end

        ENEMY_TURN: begin
          if (enemy_accept || turn_expired) begin
            player_hp_out <= player_hp_next;
            timeout_out   <= ~enemy_accept;
            state         <= (player_hp_next == 8'd0) ? LOSE : RESULT;
            timer         <= 32'd0;
            guard         <= 2'd0;
          end else begin
            timer <= timer + 32'd1;
            if (!guard_open) guard <= guard + 2'd1;
          end
        end

        RESULT: begin
          if (hold_done) begin
            state <= PLAYER_TURN;
            timer <= 32'd0;
            guard <= 2'd0;
            if (turn_count_out != 8'hFF) turn_count_out <= turn_count_out + 8'd1;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        WIN, LOSE: begin
          if (start_in) begin
            state          <= IDLE;
            player_hp_out  <= PLAYER_HP_INIT;
            enemy_hp_out   <= ENEMY_HP_INIT;
            turn_count_out <= 8'd0;
            timer          <= 32'd0;
            guard          <= 2'd0;
          end
        end

        default: begin
          state <= IDLE;
          timer <= 32'd0;
          guard <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/battle_sequencer.md
BATTLE_SEQUENCER -- requirements
Module: battle_sequencer

Interface
REQ-001 SHALL have parameter PLAYER_HP_INIT, default 8'd100, player hit points loaded at reset/restart.
REQ-002 SHALL have parameter ENEMY_HP_INIT, default 8'd200, enemy hit points loaded at reset/restart.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 32'd650_000_000, max cycles a turn waits for finished (10 s at 65 MHz).
REQ-004 SHALL have parameter RESULT_HOLD_CYCLES, default 32'd130_000_000, cycles spent in RESULT before the next turn.
REQ-005 clk  input  1  system clock; all state changes on posedge clk.
REQ-006 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 start_in  input  1  level; begins a battle from IDLE, or returns from WIN/LOSE to IDLE.
REQ-008 player_finished_in  input  1  finished flag of the player attack block.
REQ-009 player_damage_in  input  8  damage produced by the player attack; sampled with player_finished_in.
REQ-010 enemy_finished_in  input  1  finished flag of the enemy attack block.
REQ-011 enemy_damage_in  input  8  damage to the player; sampled with enemy_finished_in.
REQ-012 state_out  output  4  phase code driven to the attack blocks' state_in.
REQ-013 player_hp_out, enemy_hp_out  output  8 each  current hit points.
REQ-014 turn_count_out  output  8  completed player+enemy rounds.
REQ-015 timeout_out  output  1  one-cycle pulse when a turn is aborted by timeout.

Function
REQ-016 State encodings on state_out SHALL be: IDLE 4'b0000, PLAYER_TURN 4'b0001, ENEMY_TURN 4'b0010, RESULT 4'b0011, WIN 4'b0100, LOSE 4'b0101; state_out is registered and equals the current state.
REQ-017 IDLE -> PLAYER_TURN when start_in=1; start_in SHALL be ignored in every other state except WIN/LOSE.
REQ-018 On entry to PLAYER_TURN or ENEMY_TURN a guard counter SHALL mask the finished input for the first 2 cycles, so a stale finished flag from the previous phase is ignored.
REQ-019 PLAYER_TURN, unmasked player_finished_in=1: enemy_hp <= enemy_hp - player_damage_in, saturating at 0; next state WIN if result is 0, else ENEMY_TURN.
REQ-020 ENEMY_TURN, unmasked enemy_finished_in=1: player_hp <= player_hp - enemy_damage_in, saturating at 0; next state LOSE if result is 0, else RESULT.
REQ-021 A 32-bit turn timer SHALL clear on every state entry and increment each cycle in PLAYER_TURN/ENEMY_TURN; when it reaches TIMEOUT_CYCLES-1 without finished, the turn ends with damage 0, timeout_out pulses for 1 cycle, and the next state follows REQ-019/020 (ENEMY_TURN or RESULT).
REQ-022 Finished and timeout in the same cycle: finished SHALL win, damage applied, timeout_out stays 0.
REQ-023 RESULT SHALL last exactly RESULT_HOLD_CYCLES cycles, then go to PLAYER_TURN with turn_count_out incremented, saturating at 8'hFF.
REQ-024 WIN/LOSE SHALL hold until start_in=1, then go to IDLE with player_hp, enemy_hp and turn_count reloaded to PLAYER_HP_INIT, ENEMY_HP_INIT and 0.
REQ-025 Damage inputs SHALL only be sampled in the cycle finished is accepted; any other value on them has no effect.
REQ-026 HP arithmetic SHALL be 8-bit unsigned with no wrap-around; damage >= hp yields exactly 0.

Reset
REQ-027 With rst_n=0, asynchronously: state IDLE, state_out 4'b0000, player_hp_out=PLAYER_HP_INIT, enemy_hp_out=ENEMY_HP_INIT, turn_count_out=0, timeout_out=0, timers and guard cleared.
REQ-028 Reset asserted mid-turn SHALL abort the turn with no HP update; after release the block waits in IDLE for start_in.

Verification
REQ-029 Reset, start_in pulse, player_finished_in with damage 50 at cycle 5 -> enemy_hp_out 200->150, state_out 0001->0010 next cycle.
REQ-030 player_finished_in held high at PLAYER_TURN entry -> ignored for 2 cycles; accepted on cycle 3.
REQ-031 TIMEOUT_CYCLES=16, no finished in ENEMY_TURN -> after 16 cycles timeout_out pulses once, player_hp unchanged, state_out=0011.
REQ-032 enemy_hp=30, player damage 255 -> enemy_hp_out=0, state_out=0100; start_in -> IDLE, HP reloaded to 100/200.
REQ-033 player_hp=10, enemy damage 10 -> player_hp_out=0, state_out=0101; finished and timeout coincident -> damage applied, no timeout pulse.
REQ-034 rst_n low during ENEMY_TURN -> all outputs at reset values immediately, without waiting for a clk edge.
